// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle unsigned subtractor, diff = a - b mod 2^WIDTH,
// processing DIGIT_W bits per clock with a rippled borrow between digits.
// Valid/ready handshake on both sides; underflow is the borrow out of the MSB.
// Optional build macro ECPU_SUB_SATURATE_EN: when defined, an underflowing
// result is clamped to zero (underflow is still reported).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for operands, in_ready=1
// RUN   | one digit per edge, STEPS edges total
// DONE  | result presented with out_valid=1 until out_ready
module serial_subtractor #(
    parameter int WIDTH   = 16,
    parameter int DIGIT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             underflow
);

    localparam int STEPS = WIDTH / DIGIT_W;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // a_sh doubles as the result register: result digits enter at the top
    // as minuend digits leave at the bottom, so after STEPS edges it holds
    // the complete difference.
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_nxt;
    logic             borrow;
    logic [CNT_W-1:0] cnt;

    logic [DIGIT_W:0]   dig_full;
    logic [DIGIT_W-1:0] dig;
    logic               dig_bout;
    logic               last_step;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign last_step = (cnt == LAST_STEP);

    // One digit of a - b - borrow; the extra top bit is the digit borrow-out.
    always_comb begin
        dig_full = {1'b0, a_sh[DIGIT_W-1:0]}
                 - {1'b0, b_sh[DIGIT_W-1:0]}
                 - {{DIGIT_W{1'b0}}, borrow};
        dig      = dig_full[DIGIT_W-1:0];
        dig_bout = dig_full[DIGIT_W];
    end

    generate
        if (DIGIT_W == WIDTH) begin : g_full_digit
            assign res_nxt = dig;
        end else begin : g_part_digit
            assign res_nxt = {dig, a_sh[WIDTH-1:DIGIT_W]};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (in_valid)  state_nxt = S_RUN;
            S_RUN:  if (last_step) state_nxt = S_DONE;
            S_DONE: if (out_ready) state_nxt = S_IDLE;
            default:               state_nxt = S_IDLE;
        endcase
    end

    // Datapath: operand capture, digit-serial subtract, result publish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh      <= '0;
            b_sh      <= '0;
            borrow    <= 1'b0;
            cnt       <= '0;
            diff      <= '0;
            underflow <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        borrow <= 1'b0;
                        cnt    <= '0;
                    end
                end
                S_RUN: begin
                    a_sh   <= res_nxt;
                    b_sh   <= b_sh >> DIGIT_W;
                    borrow <= dig_bout;
                    cnt    <= cnt + CNT_W'(1);
                    // diff only changes here, so no partial result is ever visible.
                    if (last_step) begin
                        underflow <= dig_bout;
`ifdef ECPU_SUB_SATURATE_EN
                        diff      <= dig_bout ? '0 : res_nxt;
`else
                        diff      <= res_nxt;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Multi-cycle 16-bit unsigned subtractor: computes diff = a - b, processing DIGIT_W bits per clock with a rippled borrow.
- Flags underflow when b > a; underflow is the borrow out of the MSB.
- Valid/ready handshake on both sides; sits in the ALU as the subtract path that complements the adder.
- Trades latency for area.

Parameters:
- WIDTH, 16, operand/result width in bits.
- DIGIT_W, 4, bits processed per RUN cycle; must divide WIDTH exactly, 1 <= DIGIT_W <= WIDTH.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a, b present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend, unsigned.
- b  input  WIDTH  subtrahend, unsigned.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes result.
- diff  output  WIDTH  a - b mod 2^WIDTH.
- underflow  output  1  1 when b > a (final borrow).

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, out_valid=0, diff=0, underflow=0, internal borrow=0, step counter=0. After reset in_ready=1. Nothing is accepted while rst_n is low.
- STEPS = WIDTH/DIGIT_W.
- in_ready = (state==IDLE), combinational from state only.
- out_valid = (state==DONE), registered.
- IDLE:
  - On an edge with in_valid&&in_ready, latch a and b into shift registers, clear borrow and counter, go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - Each edge subtracts the low DIGIT_W bits of the a-shift minus the b-shift minus borrow, with modulo-2^DIGIT_W result.
  - Shifts the result digit into the top of the result register; both operand shifts move right by DIGIT_W.
  - Borrow updates to the digit borrow-out; counter increments.
  - On the STEPS-th RUN edge, go to DONE. diff holds the full result; underflow = final borrow.
  - in_valid is ignored during RUN.
- Latency: out_valid rises exactly STEPS edges after the accepting edge (4 cycles at defaults).
- DONE:
  - diff and underflow are held stable while out_valid=1 and out_ready=0; backpressure is unbounded.
  - On an edge with out_ready=1, go to IDLE and drop out_valid. diff and underflow retain their last values.
  - New operands are accepted no earlier than the following edge; there is no same-cycle turnaround.
- Wrap-around: the result is always mod 2^WIDTH, e.g. 0 - 1 = all-ones with underflow=1.
- a==b gives diff=0, underflow=0.
- Reset asserted mid-RUN or in DONE aborts immediately to the reset values; no partial result is ever presented.
- in_valid/a/b may change freely when not being accepted. Operands are sampled only on the accepting edge.
- With DIGIT_W==WIDTH, RUN lasts exactly one edge.

Optional Feature:
- Macro: ECPU_SUB_SATURATE_EN.
- Defined: when the final borrow is 1, diff is forced to 0 when entering DONE; underflow is still reported as 1. Non-underflowing results are unchanged. Latency is unchanged.
- Undefined: diff is the plain modulo result; there is no saturation logic.

Test Plan:
- Basic: a=0x1234, b=0x0234, out_ready=1 -> out_valid high 4 cycles after accept, diff=0x1000, underflow=0, in_ready back to 1 one cycle after the result is taken.
- Underflow/wrap: a=0x0000, b=0x0001 -> diff=0xFFFF, underflow=1. With ECPU_SUB_SATURATE_EN: diff=0x0000, underflow=1.
- Boundary: a=0xFFFF, b=0xFFFF -> diff=0x0000, underflow=0. a=0x8000, b=0x0001 -> diff=0x7FFF, underflow=0 (borrow ripples across all digits).
- Backpressure: a=0x00FF, b=0x0010, hold out_ready=0 for 10 cycles while toggling in_valid with new operands -> diff stays 0x00EF, in_ready stays 0, the new operands are not accepted. Raise out_ready -> one transfer, then IDLE.
- Reset mid-operation: drop rst_n 2 cycles into RUN -> out_valid=0, diff=0, underflow=0 immediately. After release, in_ready=1 and a new 0x0005-0x0003 yields 0x0002.
- Parameter sweep: DIGIT_W=1 (16-cycle latency) and DIGIT_W=16 (1-cycle latency), random a/b -> results match a-b mod 2^16 and underflow=(b>a).
